// File: rtl/alu.sv
// RV32I execute-stage ALU: ten operations with registered Result, Zero/Sign flags and a valid strobe.
// Optional registered signed-overflow flag enabled by defining ALU_OVERFLOW_FLAG_EN.
module alu #(
  parameter int XLEN = 32
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            In_Valid,
  input  logic [XLEN-1:0] Op1,
  input  logic [XLEN-1:0] Op2,
  input  logic [3:0]      Alu_Control,
  output logic            Out_Valid,
  output logic [XLEN-1:0] Result,
  output logic            Zero_f,
`ifdef ALU_OVERFLOW_FLAG_EN
  output logic            Sign_f,
  output logic            Overflow_f
`else
  output logic            Sign_f
`endif
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_OR   = 4'b1100;
  localparam logic [3:0] OP_AND  = 4'b1110;

  logic [XLEN-1:0] sum_s;
  logic [XLEN-1:0] diff_s;
  logic [4:0]      shamt_s;
  logic [XLEN-1:0] res_s;

  logic            valid_d, valid_q;
  logic [XLEN-1:0] result_d, result_q;
  logic            zero_d, zero_q;
  logic            sign_d, sign_q;

  // Operation datapath; undefined encodings produce zero.
  always_comb begin
    sum_s   = Op1 + Op2;
    diff_s  = Op1 - Op2;
    shamt_s = Op2[4:0];
    res_s   = {XLEN{1'b0}};
    case (Alu_Control)
      OP_ADD:  res_s = sum_s;
      OP_SUB:  res_s = diff_s;
      OP_SLL:  res_s = Op1 << shamt_s;
      OP_SLT:  res_s = {{(XLEN-1){1'b0}}, ($signed(Op1) < $signed(Op2))};
      OP_SLTU: res_s = {{(XLEN-1){1'b0}}, (Op1 < Op2)};
      OP_XOR:  res_s = Op1 ^ Op2;
      OP_SRL:  res_s = Op1 >> shamt_s;
      OP_SRA:  res_s = $unsigned($signed(Op1) >>> shamt_s);
      OP_OR:   res_s = Op1 | Op2;
      OP_AND:  res_s = Op1 & Op2;
      default: res_s = {XLEN{1'b0}};
    endcase
  end

  // Next-state for the output registers; flags come from the same value loaded into Result.
  always_comb begin
    valid_d  = In_Valid;
    result_d = result_q;
    zero_d   = zero_q;
    sign_d   = sign_q;
    if (In_Valid) begin
      result_d = res_s;
      zero_d   = (res_s == {XLEN{1'b0}});
      sign_d   = res_s[XLEN-1];
    end else begin
      result_d = result_q;
      zero_d   = zero_q;
      sign_d   = sign_q;
    end
  end

  // Output registers; Zero_f resets to 0 because flags are not yet meaningful.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      valid_q  <= 1'b0;
      result_q <= {XLEN{1'b0}};
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
    end
  end

  assign Out_Valid = valid_q;
  assign Result    = result_q;
  assign Zero_f    = zero_q;
  assign Sign_f    = sign_q;

`ifdef ALU_OVERFLOW_FLAG_EN
  logic ovf_s;
  logic ovf_d, ovf_q;

  // Signed overflow detection for ADD/SUB only.
  always_comb begin
    ovf_s = 1'b0;
    case (Alu_Control)
      OP_ADD:  ovf_s = (Op1[XLEN-1] == Op2[XLEN-1]) && (sum_s[XLEN-1] != Op1[XLEN-1]);
      OP_SUB:  ovf_s = (Op1[XLEN-1] != Op2[XLEN-1]) && (diff_s[XLEN-1] != Op1[XLEN-1]);
      default: ovf_s = 1'b0;
    endcase
  end

  // Overflow flag next-state, holding while idle.
  always_comb begin
    ovf_d = ovf_q;
    if (In_Valid) begin
      ovf_d = ovf_s;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign Overflow_f = ovf_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard testbench for alu: driver pushes model predictions per cycle, monitor pops and compares.
module tb_alu;

  logic        Clk;
  logic        Reset_n;
  logic        In_Valid;
  logic [31:0] Op1;
  logic [31:0] Op2;
  logic [3:0]  Alu_Control;
  logic        Out_Valid;
  logic [31:0] Result;
  logic        Zero_f;
  logic        Sign_f;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic        Overflow_f;
`endif

  alu #(.XLEN(32)) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .In_Valid(In_Valid),
    .Op1(Op1),
    .Op2(Op2),
    .Alu_Control(Alu_Control),
    .Out_Valid(Out_Valid),
    .Result(Result),
    .Zero_f(Zero_f),
`ifdef ALU_OVERFLOW_FLAG_EN
    .Sign_f(Sign_f),
    .Overflow_f(Overflow_f)
`else
    .Sign_f(Sign_f)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        v;
    logic [31:0] r;
    logic        z;
    logic        s;
    logic        o;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_last;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model from the operation definitions using plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    int          sa, sb;
    longint      wide;
    logic [31:0] pw;
    sa = a;
    sb = b;
    pw = 32'd1 << b[4:0];
    e  = '0;
    e.v = 1'b1;
    case (c)
      4'b0000: begin
        e.r = a + b;
        wide = longint'(sa) + longint'(sb);
        e.o = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'b0001: begin
        e.r = a - b;
        wide = longint'(sa) - longint'(sb);
        e.o = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'b0010: e.r = a * pw;
      4'b0100: e.r = (sa < sb) ? 32'd1 : 32'd0;
      4'b0110: e.r = (a < b) ? 32'd1 : 32'd0;
      4'b1000: e.r = a ^ b;
      4'b1010: e.r = a / pw;
      4'b1011: e.r = a[31] ? ~((~a) / pw) : (a / pw);
      4'b1100: e.r = a | b;
      4'b1110: e.r = a & b;
      default: e.r = 32'd0;
    endcase
    e.z = (e.r == 32'd0);
    e.s = e.r[31];
    return e;
  endfunction

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    In_Valid    = 1'b1;
    Alu_Control = c;
    Op1         = a;
    Op2         = b;
    sb_q.push_back(model(c, a, b));
  endtask

  task automatic idle();
    exp_t e;
    @(negedge Clk);
    In_Valid    = 1'b0;
    Alu_Control = 4'($urandom_range(15, 0));
    Op1         = $urandom;
    Op2         = $urandom;
    e = '0;
    sb_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, Out_Valid}, 32'd0);
    check({tag, "_result"}, Result, 32'd0);
    check({tag, "_zero"}, {31'd0, Zero_f}, 32'd0);
    check({tag, "_sign"}, {31'd0, Sign_f}, 32'd0);
`ifdef ALU_OVERFLOW_FLAG_EN
    check({tag, "_ovf"}, {31'd0, Overflow_f}, 32'd0);
`endif
  endtask

  // Monitor: one scoreboard entry per driven cycle, compared just after the capturing edge.
  initial begin
    exp_t e;
    mon_last = '0;
    forever begin
      @(posedge Clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("out_valid", {31'd0, Out_Valid}, {31'd0, e.v});
        if (e.v) mon_last = e;
        check(e.v ? "result" : "hold_result", Result, mon_last.r);
        check(e.v ? "zero_f" : "hold_zero_f", {31'd0, Zero_f}, {31'd0, mon_last.z});
        check(e.v ? "sign_f" : "hold_sign_f", {31'd0, Sign_f}, {31'd0, mon_last.s});
`ifdef ALU_OVERFLOW_FLAG_EN
        check(e.v ? "overflow_f" : "hold_overflow_f", {31'd0, Overflow_f}, {31'd0, mon_last.o});
`endif
      end
    end
  end

  initial begin
    logic [3:0] c;
    int         budget;
    Reset_n     = 1'b1;
    In_Valid    = 1'b0;
    Op1         = 32'd0;
    Op2         = 32'd0;
    Alu_Control = 4'd0;
    #2 Reset_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

    // Directed cases
    issue(4'b0000, 32'd10, 32'd5);
    issue(4'b0001, 32'd15, 32'd20);
    issue(4'b0001, 32'd7, 32'd7);
    issue(4'b0100, 32'hFFFFFFFB, 32'd1);
    issue(4'b0110, 32'hFFFFFFFB, 32'd1);
    issue(4'b0110, 32'd5, 32'd10);
    idle();
    issue(4'b0010, 32'd3, 32'd1);
    issue(4'b1010, 32'h80000000, 32'd2);
    issue(4'b1011, 32'h80000000, 32'd2);
    issue(4'b1010, 32'h80000000, 32'h00000022);
    issue(4'b1011, 32'h12345678, 32'd0);
    issue(4'b1011, 32'hF0000001, 32'd31);
    issue(4'b1000, 32'hF0F0F0F0, 32'h0F0F0F0F);
    idle();
    idle();
    issue(4'b1100, 32'hFF00FF00, 32'h00FF00FF);
    issue(4'b1110, 32'hAAAA5555, 32'hFFFF0000);
    issue(4'b0011, 32'h12345678, 32'h9ABCDEF0);
    issue(4'b0000, 32'h7FFFFFFF, 32'd1);
    idle();
    issue(4'b0001, 32'h80000000, 32'd1);
    issue(4'b0000, 32'd1, 32'd1);
    issue(4'b0000, 32'h80000000, 32'h80000000);
    idle();

    // Reset with a result in flight
    @(negedge Clk);
    In_Valid    = 1'b1;
    Alu_Control = 4'b0001;
    Op1         = 32'd0;
    Op2         = 32'd1;
    @(posedge Clk);
    #1;
    check("pre_reset_valid", {31'd0, Out_Valid}, 32'd1);
    In_Valid = 1'b0;
    #1 Reset_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    mon_last = '0;
    @(negedge Clk);
    Reset_n = 1'b1;
    idle();

    // Random traffic, with shift and illegal codes included
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3, 0) == 0) begin
        idle();
      end else begin
        c = 4'($urandom_range(15, 0));
        case ($urandom_range(3, 0))
          0:       issue(c, 32'h80000000 | $urandom, 32'($urandom_range(63, 0)));
          1:       issue(c, $urandom, $urandom & 32'h8000001F);
          default: issue(c, $urandom, $urandom);
        endcase
      end
    end
    idle();

    budget = 20;
    while (sb_q.size() > 0 && budget > 0) begin
      @(negedge Clk);
      budget--;
    end
    checks++;
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit RV32I integer ALU used by the execute stage for register-register and register-immediate ops and for branch compares.
- Operands Op1/Op2 and a 4-bit Alu_Control select one of ten operations.
- Result and the Zero/Sign flags are registered: one-cycle latency with a valid strobe.
- Sits between the operand muxes and the EX/MEM boundary.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported; the shift amount is always Op2[4:0].

Ports:
- Clk  input  1  rising-edge clock
- Reset_n  input  1  asynchronous active-low reset
- In_Valid  input  1  operands and control valid this cycle
- Op1  input  32  first operand (rs1)
- Op2  input  32  second operand (rs2 or immediate)
- Alu_Control  input  4  operation select
- Out_Valid  output  1  Result and flags valid
- Result  output  32  registered result
- Zero_f  output  1  registered (Result == 0)
- Sign_f  output  1  registered Result[31]

Behaviour:
- Encodings:
  - 0000 ADD: Op1+Op2, mod 2^32.
  - 0001 SUB: Op1-Op2, mod 2^32.
  - 0010 SLL: Op1 << Op2[4:0].
  - 0100 SLT: 1 if signed Op1 < signed Op2, else 0.
  - 0110 SLTU: same compare, unsigned.
  - 1000 XOR.
  - 1010 SRL: logical right shift by Op2[4:0], zero fill.
  - 1011 SRA: arithmetic right shift by Op2[4:0], Op1[31] fill.
  - 1100 OR.
  - 1110 AND.
- Any other code: next result = 0x00000000 (Zero_f=1, Sign_f=0). No error output.
- Op2[31:5] is ignored for shifts. A shift of 0 passes Op1 through unchanged.
- SLT/SLTU result is zero-extended: bit0 holds the compare, bits[31:1]=0.
- Flags are derived from the same 32-bit value that is loaded into Result, in the same edge.
- Latency: when In_Valid=1 at a rising Clk edge, Result/Zero_f/Sign_f load the computed values and Out_Valid=1 for the following cycle.
- When In_Valid=0 at an edge:
  - Out_Valid goes to 0.
  - Result/Zero_f/Sign_f hold their last values.
- Back-to-back In_Valid: one result per cycle. There is no stall and no backpressure.
- Reset (asynchronous assert, synchronous release): Result=0, Zero_f=0, Sign_f=0, Out_Valid=0. Zero_f is explicitly 0 at reset because the flags are not yet valid.
- Reset asserted mid-operation: the in-flight result is discarded and outputs return to reset values immediately.
- Arithmetic is purely combinational ahead of the output registers. There are no X propagation paths from undefined encodings.

Optional Feature:
- Macro ALU_OVERFLOW_FLAG_EN.
- When defined, add port Overflow_f (output, 1 bit, registered alongside Result):
  - ADD: 1 when the operands have the same sign and the result sign differs.
  - SUB: 1 when the operands have different signs and the result sign differs from Op1.
  - All other ops: 0.
  - Reset value 0. Holds when In_Valid=0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert Reset_n=0 mid-cycle → all outputs 0 immediately. Release, then ADD Op1=10, Op2=5 with In_Valid=1 → next cycle Result=0x0000000F, Zero_f=0, Sign_f=0, Out_Valid=1.
- SUB and compares:
  - SUB 15-20 → 0xFFFFFFFB, Sign_f=1.
  - SUB 7-7 → 0, Zero_f=1.
  - SLT Op1=-5, Op2=1 → 1.
  - SLTU Op1=0xFFFFFFFB, Op2=1 → 0.
  - SLTU 5,10 → 1.
- Shifts:
  - SLL 3 by 1 → 6.
  - SRL 0x80000000 by 2 → 0x20000000.
  - SRA 0x80000000 by 2 → 0xE0000000, Sign_f=1.
  - SRL with Op2=0x00000022 → shift by 2 (upper bits ignored).
- Logic:
  - XOR F0F0F0F0^0F0F0F0F → FFFFFFFF.
  - OR FF00FF00|00FF00FF → FFFFFFFF.
  - AND AAAA5555&FFFF0000 → AAAA0000.
  - Illegal code 0011 → 0, Zero_f=1.
- Handshake:
  - Back-to-back In_Valid for 4 cycles → 4 consecutive Out_Valid with matching results.
  - Drop In_Valid → Out_Valid=0 and Result holds its last value.
- Overflow (ALU_OVERFLOW_FLAG_EN defined):
  - ADD 0x7FFFFFFF+1 → 0x80000000, Overflow_f=1.
  - SUB 0x80000000-1 → Overflow_f=1.
  - ADD 1+1 → Overflow_f=0.
